// File: rtl/vram_store_drain.sv
// vram_store_drain: drains the CPU store queue into the single-port vector
// BRAM. The port is shared with vector-generator reads, which normally win.
// A starvation counter forces a bounded burst of queued writes. CPU
// addresses are mapped into the BRAM window, and out-of-window stores are
// popped and dropped. Write and drop statistics are kept.
module vram_store_drain #(
  parameter logic [15:0] BASE       = 16'h2000,
  parameter int          ADDR_W     = 13,
  parameter int          MAX_STARVE = 8,
  parameter int          BURST_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        q_data,
  input  logic [15:0]       q_addr,
  input  logic              q_valid,
  input  logic              q_empty,
  output logic              can_write,
  input  logic              vg_req,
  input  logic [ADDR_W-1:0] vg_addr,
  output logic              vg_ack,
  output logic [7:0]        vg_rdata,
  output logic              vg_rvalid,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  input  logic [7:0]        bram_dout,
  input  logic              stat_clr,
  output logic [15:0]       wr_count,
  output logic [7:0]        drop_count,
  output logic              drop_flag
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [BW-1:0] BURST_MAX  = BW'(BURST_LEN);

  typedef enum logic {ARB, BURST} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic [BW-1:0] burst_reg, burst_next;

  logic        wg;
  logic        rg;
  logic [15:0] offset;
  logic        in_range;
  logic        drop_evt;
  logic        we_int;

  // Window translation: addresses below BASE wrap to large offsets and fall out of range
  always_comb begin
    offset   = q_addr - BASE;
    in_range = (32'(offset) < (32'd1 << ADDR_W));
  end

  // Port arbitration, starvation tracking and burst sequencing
  always_comb begin
    wg          = 1'b0;
    rg          = 1'b0;
    state_next  = state_reg;
    starve_next = starve_reg;
    burst_next  = burst_reg;
    case (state_reg)
      ARB: begin
        wg = !q_empty && (!vg_req || starve_reg == STARVE_MAX);
        rg = vg_req && !wg;
        if (wg || q_empty) begin
          starve_next = '0;
        end else if (rg && starve_reg != STARVE_MAX) begin
          starve_next = starve_reg + 1'b1;
        end
        if (wg && starve_reg == STARVE_MAX) begin
          // The write that starts the burst counts towards its length
          burst_next = BW'(1);
          if (BURST_LEN > 1) begin
            state_next = BURST;
          end
        end
      end
      BURST: begin
        wg = !q_empty;
        if (wg) begin
          burst_next = burst_reg + 1'b1;
        end
        if (burst_next == BURST_MAX || q_empty) begin
          state_next = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Port drive; strobes are forced low while reset is asserted
  always_comb begin
    we_int    = wg && q_valid && in_range;
    drop_evt  = wg && q_valid && !in_range;
    can_write = rst_n && wg;
    vg_ack    = rst_n && rg;
    bram_en   = rst_n && (wg || rg);
    bram_we   = rst_n && we_int;
    bram_addr = wg ? offset[ADDR_W-1:0] : vg_addr;
    bram_din  = q_data;
    vg_rdata  = bram_dout;
  end

  // Arbiter state, counters and read-valid pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ARB;
      starve_reg <= '0;
      burst_reg  <= '0;
      vg_rvalid  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
      burst_reg  <= burst_next;
      vg_rvalid  <= rg;
    end
  end

  // Statistics; a clear in the same cycle as an event discards the event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count   <= '0;
      drop_count <= '0;
      drop_flag  <= 1'b0;
    end else if (stat_clr) begin
      wr_count   <= '0;
      drop_count <= '0;
      drop_flag  <= 1'b0;
    end else begin
      if (we_int) begin
        wr_count <= wr_count + 16'd1;
      end
      if (drop_evt) begin
        drop_flag <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_store_drain.sv
// Testbench for vram_store_drain: queue and BRAM models around the DUT,
// a table of single-store translations, plus directed sequences for
// starvation bursts, drop saturation with clear, and reset mid-burst.
module tb_vram_store_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  q_data;
  logic [15:0] q_addr;
  logic        q_valid;
  logic        q_empty;
  logic        can_write;
  logic        vg_req = 1'b0;
  logic [12:0] vg_addr = 13'h010;
  logic        vg_ack;
  logic [7:0]  vg_rdata;
  logic        vg_rvalid;
  logic        bram_en;
  logic        bram_we;
  logic [12:0] bram_addr;
  logic [7:0]  bram_din;
  logic [7:0]  bram_dout = 8'h00;
  logic        stat_clr = 1'b0;
  logic [15:0] wr_count;
  logic [7:0]  drop_count;
  logic        drop_flag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Store queue model: tail written by the stimulus, head advanced on pops
  logic [15:0] qa [0:1023];
  logic [7:0]  qd [0:1023];
  logic [9:0]  head = '0;
  logic [9:0]  tail = '0;

  assign q_empty = (head == tail);
  assign q_valid = !q_empty;
  assign q_addr  = qa[head];
  assign q_data  = qd[head];

  always @(posedge clk) begin
    if (can_write && !q_empty) head <= head + 10'd1;
  end

  // Single-port BRAM model with registered read
  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         bram_dout <= mem[bram_addr];
    end
  end

  vram_store_drain dut (
    .clk(clk), .rst_n(rst_n),
    .q_data(q_data), .q_addr(q_addr), .q_valid(q_valid), .q_empty(q_empty),
    .can_write(can_write),
    .vg_req(vg_req), .vg_addr(vg_addr), .vg_ack(vg_ack),
    .vg_rdata(vg_rdata), .vg_rvalid(vg_rvalid),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout),
    .stat_clr(stat_clr), .wr_count(wr_count), .drop_count(drop_count),
    .drop_flag(drop_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    qa[tail] = a;
    qd[tail] = d;
    tail = tail + 10'd1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic [12:0] baddr;
    logic [15:0] wr;
    logic [7:0]  drop;
  } vec_t;

  vec_t vt [9];

  initial begin
    bit exp_ack, exp_wr, prev_ack;
    int k;
    int waited;

    vt[0] = '{16'h2005, 8'hA5, 1'b1, 13'h0005, 16'd1, 8'd0};
    vt[1] = '{16'h1FFF, 8'h11, 1'b0, 13'h1FFF, 16'd1, 8'd1};
    vt[2] = '{16'h4000, 8'h22, 1'b0, 13'h0000, 16'd1, 8'd2};
    vt[3] = '{16'h3FFF, 8'h33, 1'b1, 13'h1FFF, 16'd2, 8'd2};
    vt[4] = '{16'h2000, 8'h44, 1'b1, 13'h0000, 16'd3, 8'd2};
    vt[5] = '{16'h0000, 8'h55, 1'b0, 13'h0000, 16'd3, 8'd3};
    vt[6] = '{16'hFFFF, 8'h66, 1'b0, 13'h1FFF, 16'd3, 8'd4};
    vt[7] = '{16'h3000, 8'h77, 1'b1, 13'h1000, 16'd4, 8'd4};
    vt[8] = '{16'h2010, 8'h3C, 1'b1, 13'h0010, 16'd5, 8'd4};

    // Reset with a store already waiting: strobes must stay low
    push(vt[0].addr, vt[0].data);
    @(negedge clk);
    check("rst_can_write", can_write, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_bram_we", bram_we, 0);
    check("rst_vg_ack", vg_ack, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_drop_flag", drop_flag, 0);
    check("rst_vg_rvalid", vg_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single stores with no VG traffic
    for (int i = 0; i < 9; i++) begin
      if (i != 0) push(vt[i].addr, vt[i].data);
      #1;
      check("vec_can_write", can_write, 1);
      check("vec_bram_en", bram_en, 1);
      check("vec_bram_we", bram_we, vt[i].we);
      check("vec_bram_addr", bram_addr, vt[i].baddr);
      check("vec_bram_din", bram_din, vt[i].data);
      @(posedge clk);
      @(negedge clk);
      check("vec_q_empty", q_empty, 1);
      check("vec_can_write_idle", can_write, 0);
      check("vec_wr_count", wr_count, vt[i].wr);
      check("vec_drop_count", drop_count, vt[i].drop);
      check("vec_drop_flag", drop_flag, vt[i].drop != 0);
      $display("vec %0d addr=%h data=%h we=%0d baddr=%h wr=%0d drop=%0d",
               i, vt[i].addr, vt[i].data, bram_we, bram_addr, wr_count, drop_count);
    end

    // Starvation: continuous VG reads of 0x010 against six queued stores
    for (int i = 0; i < 6; i++) push(16'h2100 + 16'(i), 8'h80 + 8'(i));
    vg_req = 1'b1;
    prev_ack = 1'b0;
    k = 0;
    for (int c = 1; c <= 24; c++) begin
      #1;
      exp_ack = (c <= 8) || (c >= 13 && c <= 20) || (c >= 24);
      exp_wr  = (c >= 9 && c <= 12) || (c == 21) || (c == 22);
      check("stv_vg_ack", vg_ack, exp_ack);
      check("stv_can_write", can_write, exp_wr);
      check("stv_vg_rvalid", vg_rvalid, prev_ack);
      if (prev_ack) check("stv_vg_rdata", vg_rdata, 8'h3C);
      if (exp_wr) begin
        check("stv_bram_addr", bram_addr, 13'h0100 + 13'(k));
        k++;
      end else if (exp_ack) begin
        check("stv_rd_addr", bram_addr, 13'h0010);
      end
      $display("stv cycle %0d ack=%0d wr=%0d rvalid=%0d rdata=%h",
               c, vg_ack, can_write, vg_rvalid, vg_rdata);
      prev_ack = exp_ack;
      @(posedge clk);
      @(negedge clk);
    end
    vg_req = 1'b0;
    #1;
    check("stv_wr_count", wr_count, 16'd11);

    // Drop saturation, then a clear coinciding with a drop
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    check("clr_wr_count", wr_count, 0);
    check("clr_drop_flag", drop_flag, 0);
    @(negedge clk);
    for (int i = 0; i < 300; i++) push(16'h1000, 8'(i));
    for (int i = 0; i < 299; i++) @(posedge clk);
    @(negedge clk);
    check("sat_drop_count", drop_count, 8'd255);
    check("sat_drop_flag", drop_flag, 1);
    check("sat_can_write", can_write, 1);
    check("sat_bram_we", bram_we, 0);
    stat_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    check("sat_clr_drop_count", drop_count, 0);
    check("sat_clr_drop_flag", drop_flag, 0);
    check("sat_clr_wr_count", wr_count, 0);
    check("sat_q_empty", q_empty, 1);
    $display("sat drop_count=%0d drop_flag=%0d wr=%0d", drop_count, drop_flag, wr_count);

    // Reset during a burst after two of its four writes
    @(negedge clk);
    for (int i = 0; i < 6; i++) push(16'h2200 + 16'(i), 8'hC0 + 8'(i));
    vg_req = 1'b1;
    for (int i = 0; i < 10; i++) @(posedge clk);
    @(negedge clk);
    #1;
    check("mid_can_write", can_write, 1);
    check("mid_bram_addr", bram_addr, 13'h0202);
    rst_n = 1'b0;
    #1;
    check("mid_rst_can_write", can_write, 0);
    check("mid_rst_vg_ack", vg_ack, 0);
    check("mid_rst_bram_en", bram_en, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_vg_ack", vg_ack, 1);
    check("post_rst_can_write", can_write, 0);
    @(posedge clk);
    @(negedge clk);
    vg_req = 1'b0;
    #1;
    check("post_rst_wr_can_write", can_write, 1);
    check("post_rst_bram_we", bram_we, 1);
    check("post_rst_bram_addr", bram_addr, 13'h0202);
    check("post_rst_wr_count", wr_count, 0);
    waited = 0;
    while (!q_empty && waited < 20) begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    check("drain_q_empty", q_empty, 1);
    check("drain_wr_count", wr_count, 16'd4);
    check("drain_drop_count", drop_count, 0);
    $display("rst drain cycles=%0d wr=%0d", waited, wr_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
